// File: rtl/sysid_check_sequencer.sv
// Avalon-MM master that reads the sysid ID and timestamp words, compares them against
// build-time constants and reports pass/fail/timeout. Optional macro: SYSID_CHECK_AUTOSTART_EN.
module sysid_check_sequencer #(
    parameter logic [31:0] EXPECTED_ID    = 32'hACD5CD02,
    parameter logic [31:0] EXPECTED_TS    = 32'h591C4BB7,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        av_address,
    output logic        av_read,
    input  logic        av_waitrequest,
    input  logic [31:0] av_readdata,
    input  logic        av_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] sysid_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retry_count
);

    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ID_REQ  = 3'd1,
        ST_ID_WAIT = 3'd2,
        ST_TS_REQ  = 3'd3,
        ST_TS_WAIT = 3'd4,
        ST_CHECK   = 3'd5,
        ST_RETRY   = 3'd6
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] to_cnt_r;
    logic        av_address_r;
    logic        av_read_r;
    logic        busy_r;
    logic        done_r;
    logic        id_ok_r;
    logic        ts_ok_r;
    logic        timeout_r;
    logic [31:0] sysid_value_r;
    logic [31:0] ts_value_r;
    logic [3:0]  retry_count_r;

    logic        start_s;
    logic        in_req_s;
    logic        in_read_s;
    logic        accept_s;
    logic        capture_s;
    logic        capture_id_s;
    logic        capture_ts_s;
    logic        expire_s;
    logic        retry_avail_s;
    logic        launch_s;
    logic        load_cnt_s;

    function automatic logic word_match(input logic [31:0] actual, input logic [31:0] expected);
        return (actual == expected);
    endfunction

`ifdef SYSID_CHECK_AUTOSTART_EN
    logic auto_r;

    // One synthetic start on the first cycle after reset is released
    always_ff @(posedge clock) begin
        if (reset) begin
            auto_r <= 1'b1;
        end else begin
            auto_r <= 1'b0;
        end
    end

    assign start_s = start | auto_r;
`else
    assign start_s = start;
`endif

    // Bus handshake decode; a zero-latency slave may return data in the accept cycle
    always_comb begin
        in_req_s      = (state_r == ST_ID_REQ) || (state_r == ST_TS_REQ);
        in_read_s     = in_req_s || (state_r == ST_ID_WAIT) || (state_r == ST_TS_WAIT);
        accept_s      = in_req_s && !av_waitrequest;
        if (in_req_s) begin
            capture_s = accept_s && av_readdatavalid;
        end else if (in_read_s) begin
            capture_s = av_readdatavalid;
        end else begin
            capture_s = 1'b0;
        end
        capture_id_s  = capture_s && ((state_r == ST_ID_REQ) || (state_r == ST_ID_WAIT));
        capture_ts_s  = capture_s && ((state_r == ST_TS_REQ) || (state_r == ST_TS_WAIT));
        expire_s      = in_read_s && !capture_s && (to_cnt_r == TO_LAST);
        retry_avail_s = (retry_count_r < RETRY_MAX);
    end

    // Next-state logic; a start landing on the done cycle is dropped
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s && !done_r) begin
                    state_s = ST_ID_REQ;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ID_REQ, ST_ID_WAIT: begin
                if (capture_s) begin
                    state_s = ST_TS_REQ;
                end else if (expire_s) begin
                    state_s = retry_avail_s ? ST_RETRY : ST_IDLE;
                end else if (accept_s) begin
                    state_s = ST_ID_WAIT;
                end else begin
                    state_s = state_r;
                end
            end
            ST_TS_REQ, ST_TS_WAIT: begin
                if (capture_s) begin
                    state_s = ST_CHECK;
                end else if (expire_s) begin
                    state_s = retry_avail_s ? ST_RETRY : ST_IDLE;
                end else if (accept_s) begin
                    state_s = ST_TS_WAIT;
                end else begin
                    state_s = state_r;
                end
            end
            ST_CHECK: state_s = ST_IDLE;
            ST_RETRY: state_s = ST_ID_REQ;
            default:  state_s = ST_IDLE;
        endcase
        launch_s   = (state_r == ST_IDLE) && (state_s == ST_ID_REQ);
        load_cnt_s = ((state_s == ST_ID_REQ) && (state_r != ST_ID_REQ)) ||
                     ((state_s == ST_TS_REQ) && (state_r != ST_TS_REQ));
    end

    // State, per-read timeout counter and registered bus outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            to_cnt_r     <= 16'd0;
            av_read_r    <= 1'b0;
            av_address_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            av_read_r    <= (state_s == ST_ID_REQ) || (state_s == ST_TS_REQ);
            av_address_r <= (state_s == ST_TS_REQ) || (state_s == ST_TS_WAIT);
            if (load_cnt_s) begin
                to_cnt_r <= 16'd0;
            end else if (in_read_s) begin
                to_cnt_r <= to_cnt_r + 16'd1;
            end else begin
                to_cnt_r <= 16'd0;
            end
        end
    end

    // Status and result registers; results hold until the next accepted start
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            id_ok_r       <= 1'b0;
            ts_ok_r       <= 1'b0;
            timeout_r     <= 1'b0;
            sysid_value_r <= 32'd0;
            ts_value_r    <= 32'd0;
            retry_count_r <= 4'd0;
        end else begin
            done_r <= 1'b0;
            if (launch_s) begin
                busy_r        <= 1'b1;
                id_ok_r       <= 1'b0;
                ts_ok_r       <= 1'b0;
                timeout_r     <= 1'b0;
                retry_count_r <= 4'd0;
            end
            if (capture_id_s) begin
                sysid_value_r <= av_readdata;
            end
            if (capture_ts_s) begin
                ts_value_r <= av_readdata;
            end
            if (expire_s) begin
                if (retry_avail_s) begin
                    retry_count_r <= retry_count_r + 4'd1;
                end else begin
                    timeout_r <= 1'b1;
                    done_r    <= 1'b1;
                    busy_r    <= 1'b0;
                end
            end
            if (state_r == ST_CHECK) begin
                id_ok_r <= word_match(sysid_value_r, EXPECTED_ID);
                ts_ok_r <= word_match(ts_value_r, EXPECTED_TS);
                done_r  <= 1'b1;
                busy_r  <= 1'b0;
            end
        end
    end

    assign av_address  = av_address_r;
    assign av_read     = av_read_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign id_ok       = id_ok_r;
    assign ts_ok       = ts_ok_r;
    assign timeout     = timeout_r;
    assign sysid_value = sysid_value_r;
    assign ts_value    = ts_value_r;
    assign retry_count = retry_count_r;

endmodule
